jt51_pm_sched: RTL and testbench
================================

JT51_PM_SCHED -- requirements
Module: jt51_pm_sched

Interface
REQ-001 The block SHALL have parameter PM_EN, default 1, meaning: when 0, the modulation operand is forced to 0 for every channel.
REQ-002 clk  input  1  system clock; every flop SHALL be clocked on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 cen  input  1  clock enable; all state SHALL advance only when cen=1, except the done pulse timing defined in REQ-019.
REQ-005 wr  input  1  channel configuration write strobe.
REQ-006 wr_ch  input  3  channel index for the configuration write.
REQ-007 wr_kc  input  7  key code to store for wr_ch.
REQ-008 wr_kf  input  6  key fraction to store for wr_ch.
REQ-009 pm_valid  input  1  strobe meaning a new LFO pitch-modulation sample is present.
REQ-010 pm_mod  input  9  modulation magnitude.
REQ-011 pm_add  input  1  modulation sign: 1 adds, 0 subtracts.
REQ-012 rd_ch  input  3  read channel select.
REQ-013 kcex  output  13  extended key code of rd_ch, read combinationally from the result table.
REQ-014 busy  output  1  high while any channel is pending recomputation.
REQ-015 done  output  1  one-clk pulse when a sweep empties the pending set.

Function
- REQ-016 Storage: the block SHALL hold an 8-entry kc/kf table, an 8-entry 13-bit result table, an 8-bit dirty mask, a 3-bit round-robin pointer, and latched mod_q[8:0] / add_q.
- REQ-017 Writes: when wr=1 and cen=1, the block SHALL store wr_kc/wr_kf at wr_ch and set dirty[wr_ch].
- REQ-018 LFO update: when pm_valid=1 and cen=1, the block SHALL latch pm_mod (or 0 if PM_EN=0) and pm_add into mod_q/add_q, and set all 8 dirty bits.
- REQ-019 FSM states SHALL be IDLE and RUN.
  - IDLE->RUN on the first cen cycle with the dirty mask nonzero.
  - RUN->IDLE on the cen cycle that clears the last dirty bit, with no new dirty bit set in that cycle.
  - done SHALL pulse for exactly one clk on the RUN->IDLE transition edge.
- REQ-020 Per-channel service in RUN, one channel per cen cycle:
  - select the first dirty channel at or after the pointer, wrapping 7->0;
  - drive the shared PM datapath with that channel's kc/kf and mod_q/add_q;
  - write the result into the result table at the end of the same cen cycle;
  - clear the channel's dirty bit;
  - set the pointer to channel+1 mod 8.
- REQ-021 Latency: a result SHALL be visible on kcex at most 8 cen cycles after the cen cycle that dirtied it. A full sweep after pm_valid SHALL take exactly 8 cen cycles.
- REQ-022 Arithmetic:
  - kc with kc[1:0]=3 SHALL be advanced to the next valid code.
  - Overflow, including carry out of kc, SHALL saturate to 13'h1FBF (octave 7, note 14, fraction 63).
  - Subtract underflow SHALL clamp to 13'h0000.
  - Result codes SHALL never have bits [7:6]=3.
- REQ-023 Simultaneous write and service of the same channel: the dirty bit SHALL remain set, so the channel is recomputed with the new values.
- REQ-024 Simultaneous pm_valid and service: the serviced result uses the old mod_q, and all 8 channels SHALL be re-dirtied; no sweep restart is required.
- REQ-025 wr and pm_valid in the same cycle SHALL both take effect.
- REQ-026 When cen=0, no table, mask, pointer or FSM state SHALL change, and wr/pm_valid SHALL be ignored.
- REQ-027 busy SHALL equal (dirty mask != 0) registered, i.e. high from the cycle after dirtying through the cycle of the final clear.

Reset
- REQ-028 On rst_n=0 at a rising clk edge, regardless of cen:
  - kc/kf table, result table, dirty mask, pointer, mod_q, add_q SHALL be 0;
  - state SHALL be IDLE;
  - busy and done SHALL be 0.
- REQ-029 Reset mid-sweep SHALL abandon the sweep and clear all pending work, with no done pulse.

Structure
- REQ-030 The saturation constant 13'h1FBF, the channel count 8, and the FSM state encodings SHALL live in the shared jt51 package/include.
- REQ-031 The PM arithmetic SHALL be one combinational sub-module instance, jt51_pm, shared by all channels; the scheduler SHALL NOT duplicate its arithmetic.

Verification
- REQ-032 Basic sweep: write ch3 kc=7'h4A kf=0, then pm_valid with mod=0, add=1 -> within 8 cen cycles kcex(rd_ch=3)=13'h1280, done pulses once, busy then 0.
- REQ-033 Positive saturation:
  - ch0 kc=7'h7E kf=63, pm_valid mod=511 add=1 -> kcex(0)=13'h1FBF;
  - ch1 kc=7'h7F with mod=0 -> kcex(1)=13'h1FBF (carry case).
- REQ-034 Underflow: ch2 kc=0 kf=0, pm_valid mod=256 add=0 -> kcex(2)=13'h0000.
- REQ-035 Collision: during RUN, write ch5 kc=7'h20 in the cycle ch5 is serviced -> ch5 is serviced again and the final kcex(5)=13'h0800 (mod=0); done pulses only after the recompute.
- REQ-036 cen gating:
  - hold cen=0 for 20 clks mid-sweep -> table, busy and pointer are frozen;
  - resuming completes the sweep in the remaining cen cycles (8 total).
- REQ-037 Reset mid-sweep: assert rst_n=0 one cycle after pm_valid -> all kcex read 0, busy=0, no done pulse.

Source files
------------

// File: rtl/jt51_pm_sched_pkg.sv
// jt51_pm_sched_pkg: constants and FSM encoding shared by the PM scheduler and its datapath
package jt51_pm_sched_pkg;
    localparam int          NCH     = 8;
    localparam logic [12:0] KC_SAT  = 13'h1FBF;
    localparam logic [13:0] LIN_MAX = 14'd6143;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/jt51_pm.sv
// jt51_pm: combinational pitch modulation of a kc/kf pair on a 12-note-per-octave scale
module jt51_pm
    import jt51_pm_sched_pkg::*;
(
    input  logic [6:0]  i_kc,
    input  logic [5:0]  i_kf,
    input  logic [8:0]  i_mod,
    input  logic        i_add,
    output logic [12:0] o_kcex
);
    // kc[1:0]=3 maps onto the following note, so invalid codes advance for free
    logic [6:0]  w_semi, w_idx;
    logic [13:0] w_lin, w_sum;
    logic [3:0]  w_n;
    logic        w_carry, w_under, w_over;
    assign w_semi  = 7'(i_kc[6:4]) * 7'd12 + 7'(i_kc[3:2]) * 7'd3 + 7'(i_kc[1:0]);
    assign w_carry = w_semi == 7'd96;
    assign w_lin   = {1'b0, w_semi, i_kf};
    assign w_under = !i_add && w_lin < 14'(i_mod);
    assign w_sum   = i_add ? w_lin + 14'(i_mod) : w_lin - 14'(i_mod);
    assign w_over  = w_carry || (!w_under && w_sum > LIN_MAX);
    assign w_idx   = w_sum[12:6];
    assign w_n     = 4'(w_idx % 7'd12);
    assign o_kcex  = w_over ? KC_SAT : w_under ? 13'h0000 :
                     {3'(w_idx / 7'd12), w_n + w_n / 4'd3, w_sum[5:0]};
endmodule

// File: rtl/jt51_pm_sched.sv
// jt51_pm_sched: round-robin recompute of per-channel pitch-modulated key codes
module jt51_pm_sched
    import jt51_pm_sched_pkg::*;
#(
    parameter bit PM_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        wr,
    input  logic [2:0]  wr_ch,
    input  logic [6:0]  wr_kc,
    input  logic [5:0]  wr_kf,
    input  logic        pm_valid,
    input  logic [8:0]  pm_mod,
    input  logic        pm_add,
    input  logic [2:0]  rd_ch,
    output logic [12:0] kcex,
    output logic        busy,
    output logic        done
);
    logic [6:0]     r_kc  [NCH];
    logic [5:0]     r_kf  [NCH];
    logic [12:0]    r_res [NCH];
    logic [NCH-1:0] r_dirty, w_dirty_nxt, w_clr, w_set;
    logic [2:0]     r_ptr, w_sel;
    logic [8:0]     r_mod;
    logic           r_add, r_done, w_svc, w_done;
    logic [12:0]    w_kcex;
    state_t         r_state, w_state_nxt;
    // Set bits win over the service clear, so a colliding write gets recomputed
    always_comb begin
        w_sel = r_ptr;
        for (int i = NCH - 1; i >= 0; i--)
            if (r_dirty[r_ptr + 3'(i)]) w_sel = r_ptr + 3'(i);
        w_svc       = cen && r_state == RUN;
        w_clr       = w_svc ? NCH'(1) << w_sel : '0;
        w_set       = (cen && wr ? NCH'(1) << wr_ch : '0) | {NCH{cen && pm_valid}};
        w_dirty_nxt = (r_dirty & ~w_clr) | w_set;
        w_state_nxt = !cen ? r_state : |w_dirty_nxt ? RUN : IDLE;
        w_done      = cen && r_state == RUN && w_state_nxt == IDLE;
    end
    jt51_pm u_pm (
        .i_kc   (r_kc[w_sel]),
        .i_kf   (r_kf[w_sel]),
        .i_mod  (r_mod),
        .i_add  (r_add),
        .o_kcex (w_kcex)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_kc[i]  <= '0;
                r_kf[i]  <= '0;
                r_res[i] <= '0;
            end
            r_dirty <= '0;
            r_ptr   <= '0;
            r_mod   <= '0;
            r_add   <= 1'b0;
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_done;
            if (cen) begin
                r_dirty <= w_dirty_nxt;
                r_state <= w_state_nxt;
                if (w_svc) begin
                    r_res[w_sel] <= w_kcex;
                    r_ptr        <= w_sel + 3'd1;
                end
                if (wr) begin
                    r_kc[wr_ch] <= wr_kc;
                    r_kf[wr_ch] <= wr_kf;
                end
                if (pm_valid) begin
                    r_mod <= PM_EN ? pm_mod : '0;
                    r_add <= pm_add;
                end
            end
        end
    end
    assign kcex = r_res[rd_ch];
    assign busy = |r_dirty;
    assign done = r_done;
endmodule

// File: tb/tb_jt51_pm_sched.sv
// tb_jt51_pm_sched: directed and randomized checks of the PM scheduler against a note-walking model
module tb_jt51_pm_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  wr_ch = '0;
    logic [6:0]  wr_kc = '0;
    logic [5:0]  wr_kf = '0;
    logic        pm_valid = 1'b0;
    logic [8:0]  pm_mod = '0;
    logic        pm_add = 1'b0;
    logic [2:0]  rd_ch = '0;
    logic [12:0] kcex;
    logic        busy, done;
    int n_chk = 0, n_err = 0, n_done = 0;
    int m_kc [8];
    int m_kf [8];
    int m_mod = 0, m_add = 0;
    bit [7:0] m_touch = '0;

    jt51_pm_sched #(.PM_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .wr_ch(wr_ch), .wr_kc(wr_kc),
        .wr_kf(wr_kf), .pm_valid(pm_valid), .pm_mod(pm_mod), .pm_add(pm_add),
        .rd_ch(rd_ch), .kcex(kcex), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Walk the list of valid codes (low two bits never 3) instead of doing arithmetic on fields
    function automatic int pm_ref(input int kc, input int kf, input int md, input int ad);
        int code = (kc % 4 == 3) ? kc + 1 : kc;
        int pos = 0;
        int lin;
        if (code > 127) return 'h1FBF;
        for (int c = 0; c < code; c++) if (c % 4 != 3) pos++;
        lin = pos * 64 + kf + (ad != 0 ? md : -md);
        if (lin < 0) return 0;
        if (lin >= 96 * 64) return 'h1FBF;
        pos = lin / 64;
        for (int c = 0; c < 128; c++)
            if (c % 4 != 3) begin
                if (pos == 0) return c * 64 + lin % 64;
                pos--;
            end
        return -1;
    endfunction

    function automatic int exp_ch(input int ch);
        return m_touch[ch] ? pm_ref(m_kc[ch], m_kf[ch], m_mod, m_add) : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (!rst_n) begin
            m_touch = '0;
            m_mod = 0;
            m_add = 0;
            for (int i = 0; i < 8; i++) begin
                m_kc[i] = 0;
                m_kf[i] = 0;
            end
        end else if (cen) begin
            if (wr) begin
                m_kc[wr_ch] = int'(wr_kc);
                m_kf[wr_ch] = int'(wr_kf);
                m_touch[wr_ch] = 1'b1;
            end
            if (pm_valid) begin
                m_mod = int'(pm_mod);
                m_add = int'(pm_add);
                m_touch = '1;
            end
        end
        @(posedge clk);
        #1;
        if (done) n_done++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cen = 1'b0;
        wr = 1'b0;
        pm_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cen = 1'b1;
    endtask

    task automatic write(input int ch, input int kc, input int kf);
        cen = 1'b1;
        wr = 1'b1;
        wr_ch = 3'(ch);
        wr_kc = 7'(kc);
        wr_kf = 6'(kf);
        tick();
        wr = 1'b0;
    endtask

    task automatic lfo(input int md, input int ad);
        cen = 1'b1;
        pm_valid = 1'b1;
        pm_mod = 9'(md);
        pm_add = 1'(ad);
        tick();
        pm_valid = 1'b0;
    endtask

    // Counts cen cycles until busy drops; clock cycles are bounded
    task automatic drain(input string tag, input bit rnd_cen, output int ncen);
        int clks = 0;
        ncen = 0;
        wr = 1'b0;
        pm_valid = 1'b0;
        while (busy && clks < 100) begin
            cen = rnd_cen ? ($urandom % 3 != 0) : 1'b1;
            if (cen) ncen++;
            tick();
            clks++;
        end
        cen = 1'b1;
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_all(input string tag);
        for (int ch = 0; ch < 8; ch++) begin
            rd_ch = 3'(ch);
            #0.5;
            chk($sformatf("%s_ch%0d", tag, ch), kcex, exp_ch(ch));
        end
    endtask

    initial begin
        int n, m1, m2, bsy;
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        check_all("rst");

        write(3, 'h4A, 0);
        lfo(0, 1);
        n_done = 0;
        drain("sweep", 1'b0, n);
        chk("sweep_len", n, 8);
        chk("sweep_done", n_done, 1);
        rd_ch = 3;
        #0.5;
        chk("sweep_kc3", kcex, 'h1280);

        write(0, 'h7E, 63);
        write(1, 'h7F, 0);
        lfo(511, 1);
        drain("satp", 1'b0, n);
        rd_ch = 0;
        #0.5;
        chk("sat_kc0", kcex, 'h1FBF);
        lfo(0, 1);
        drain("carry", 1'b0, n);
        rd_ch = 1;
        #0.5;
        chk("carry_kc1", kcex, 'h1FBF);

        write(2, 0, 0);
        lfo(256, 0);
        drain("under", 1'b0, n);
        rd_ch = 2;
        #0.5;
        chk("under_kc2", kcex, 0);
        check_all("under");

        do_reset();
        lfo(0, 1);
        n_done = 0;
        for (int k = 1; k <= 9; k++) begin
            wr = (k == 6);
            wr_ch = 3'd5;
            wr_kc = 7'h20;
            wr_kf = 6'd0;
            tick();
            if (k == 8) begin
                chk("coll_busy", busy, 1);
                chk("coll_early_done", n_done, 0);
            end
        end
        wr = 1'b0;
        chk("coll_done", done, 1);
        rd_ch = 5;
        #0.5;
        chk("coll_kc5", kcex, 'h0800);
        tick();
        chk("coll_pulse", done, 0);
        chk("coll_ndone", n_done, 1);

        do_reset();
        for (int ch = 0; ch < 8; ch++) write(ch, $urandom_range(0, 127), $urandom_range(0, 63));
        m1 = $urandom_range(1, 511);
        m2 = $urandom_range(1, 511);
        lfo(m1, 1);
        drain("gate_pre", 1'b0, n);
        lfo(m2, 0);
        for (int k = 0; k < 3; k++) tick();
        n_done = 0;
        cen = 1'b0;
        wr = 1'b1;
        wr_ch = 3'd4;
        wr_kc = 7'h11;
        pm_valid = 1'b1;
        pm_mod = 9'(m1 ^ 9'h1AA);
        for (int k = 0; k < 20; k++) tick();
        wr = 1'b0;
        pm_valid = 1'b0;
        chk("gate_busy", busy, 1);
        chk("gate_done", n_done, 0);
        for (int ch = 0; ch < 8; ch++) begin
            rd_ch = 3'(ch);
            #0.5;
            chk($sformatf("gate_frz_ch%0d", ch), kcex,
                ch < 3 ? pm_ref(m_kc[ch], m_kf[ch], m2, 0) : pm_ref(m_kc[ch], m_kf[ch], m1, 1));
        end
        cen = 1'b1;
        drain("gate", 1'b0, n);
        chk("gate_rest", n, 5);
        chk("gate_ndone", n_done, 1);
        check_all("gate_end");

        n_done = 0;
        lfo($urandom_range(0, 511), 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rmid_busy", busy, 0);
        check_all("rmid");
        for (int k = 0; k < 4; k++) tick();
        chk("rmid_done", n_done, 0);

        for (int it = 0; it < 30; it++) begin
            for (int k = $urandom_range(1, 6); k > 0; k--) begin
                cen = ($urandom % 4 != 0);
                wr = $urandom % 2;
                wr_ch = 3'($urandom);
                wr_kc = 7'($urandom);
                wr_kf = 6'($urandom);
                pm_valid = ($urandom % 6 == 0);
                pm_mod = 9'($urandom);
                pm_add = 1'($urandom);
                tick();
            end
            wr = 1'b0;
            pm_valid = 1'b0;
            bsy = busy;
            n_done = 0;
            drain("rnd", 1'b1, n);
            chk("rnd_lat", n <= 8, 1);
            if (bsy != 0) chk("rnd_done", n_done, 1);
            check_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
